// File: rtl/jt12_pkg.sv
// Shared constants and types for the JT12 status-flag and write-busy logic.
// Flag vectors are ordered {ZERO, BRDY, EOS, B, A}.
`timescale 1ns/1ps
package jt12_pkg;

  localparam int FLAG_A    = 0;
  localparam int FLAG_B    = 1;
  localparam int FLAG_EOS  = 2;
  localparam int FLAG_BRDY = 3;
  localparam int FLAG_ZERO = 4;
  localparam int NUM_FLAGS = 5;

  localparam int BUSY_CYCLES_DEF = 32;
  localparam int BUSY_CNT_W      = 8;

  typedef logic [NUM_FLAGS-1:0]  flag_vec_t;
  typedef logic [BUSY_CNT_W-1:0] busy_cnt_t;

  // Applies one cycle of the flag rules: mask forcing beats a set event,
  // and a set event beats a clear.
  function automatic flag_vec_t flag_next(input flag_vec_t cur,
                                          input flag_vec_t set_ev,
                                          input flag_vec_t clr_ev,
                                          input flag_vec_t mask);
    return ((cur & ~clr_ev) | set_ev) & ~mask;
  endfunction

endpackage

// File: rtl/jt12_busy_cnt.sv
// Write-busy timer: a data write loads the counter, cen-qualified cycles count it
// down, and busy is held until the cycle after the count has reached zero.
`timescale 1ns/1ps
module jt12_busy_cnt
  import jt12_pkg::*;
#(
  parameter int BUSY_CYCLES = BUSY_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic cen,
  input  logic load,
  output logic busy
);

  localparam busy_cnt_t LOAD_VAL = busy_cnt_t'(BUSY_CYCLES);

  busy_cnt_t cnt_q, cnt_d;
  logic      busy_q, busy_d;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    cnt_d  = cnt_q;
    // A reload while counting keeps busy_d high, so busy never dips on a re-write.
    busy_d = load | (cnt_q != '0);
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (cen && (cnt_q != '0)) begin
      cnt_d = cnt_q - busy_cnt_t'(1);
    end
  end

  // NOTE: state uses <= so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/jt12_flags.sv
// JT12 status flags: maskable sticky timer/ADPCM flags, registered active-low IRQ,
// and the write-busy indicator (delegated to jt12_busy_cnt).
`timescale 1ns/1ps
module jt12_flags
  import jt12_pkg::*;
#(
  parameter int BUSY_CYCLES = BUSY_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       write,
  input  logic       a0,
  input  logic       flagctl_we,
  input  logic [7:0] din,
  input  logic       clr_A,
  input  logic       clr_B,
  input  logic       ovf_A,
  input  logic       ovf_B,
  input  logic       eos_ev,
  input  logic       brdy_ev,
  input  logic       zero_lvl,
  output logic       busy,
  output logic       flag_A,
  output logic       flag_B,
  output logic [2:0] adpcm_flags,
  output logic       irq_n
);

  flag_vec_t mask_q, mask_d;
  flag_vec_t flags_q, flags_d;
  flag_vec_t set_ev, clr_ev;
  logic      zero_prev_q, zero_prev_d;
  logic      irq_n_q, irq_n_d;
  logic      flag_reset;
  logic      unused_din;

  assign flag_reset = flagctl_we & din[7];
  assign unused_din = ^din[6:5];

  always_comb begin
    set_ev            = '0;
    set_ev[FLAG_A]    = ovf_A;
    set_ev[FLAG_B]    = ovf_B;
    set_ev[FLAG_EOS]  = eos_ev;
    set_ev[FLAG_BRDY] = brdy_ev;
    set_ev[FLAG_ZERO] = zero_lvl & ~zero_prev_q;

    clr_ev         = {NUM_FLAGS{flag_reset}};
    clr_ev[FLAG_A] = clr_ev[FLAG_A] | clr_A;
    clr_ev[FLAG_B] = clr_ev[FLAG_B] | clr_B;

    // The flag-reset write carries no mask, so the mask only loads when din[7]=0.
    mask_d = mask_q;
    if (flagctl_we && !din[7]) begin
      mask_d = din[NUM_FLAGS-1:0];
    end

    // Forcing uses the incoming mask so a newly masked flag drops on the write edge.
    flags_d     = flag_next(flags_q, set_ev, clr_ev, mask_d);
    zero_prev_d = zero_lvl;
    irq_n_d     = ~|flags_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q      <= '0;
      flags_q     <= '0;
      zero_prev_q <= 1'b0;
      irq_n_q     <= 1'b1;
    end else begin
      mask_q      <= mask_d;
      flags_q     <= flags_d;
      zero_prev_q <= zero_prev_d;
      irq_n_q     <= irq_n_d;
    end
  end

  jt12_busy_cnt #(
    .BUSY_CYCLES (BUSY_CYCLES)
  ) u_busy_cnt (
    .clk  (clk),
    .rst  (rst),
    .cen  (cen),
    .load (write & a0),
    .busy (busy)
  );

  assign flag_A      = flags_q[FLAG_A];
  assign flag_B      = flags_q[FLAG_B];
  assign adpcm_flags = {flags_q[FLAG_ZERO], flags_q[FLAG_BRDY], flags_q[FLAG_EOS]};
  assign irq_n       = irq_n_q;

endmodule

// File: doc/jt12_flags.md
JT12_FLAGS -- requirements
Module: jt12_flags

Interface
REQ-001 SHALL provide parameter BUSY_CYCLES, default 32, meaning the number of cen-qualified cycles busy stays high after a data write (legal range 1..255).
REQ-002 SHALL provide port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 SHALL provide port rst, input, 1, reset; asynchronous, active-high.
REQ-004 SHALL provide port cen, input, 1, clock enable for the busy countdown only.
REQ-005 SHALL provide port write, input, 1, one-cycle CPU write strobe.
REQ-006 SHALL provide port a0, input, 1, address bit: 0 = address write, 1 = data write.
REQ-007 SHALL provide port flagctl_we, input, 1, one-cycle strobe for a write to flag-control register 0x110 (decoded upstream).
REQ-008 SHALL provide port din, input, 8, CPU data bus.
REQ-009 SHALL provide ports clr_A and clr_B, input, 1 each, timer flag reset pulses from register 0x27.
REQ-010 SHALL provide ports ovf_A, ovf_B, eos_ev and brdy_ev, input, 1 each, event pulses for timer A, timer B, ADPCM end-of-sample and ADPCM buffer-ready.
REQ-011 SHALL provide port zero_lvl, input, 1, ADPCM zero level.
REQ-012 SHALL provide port busy, output, 1, write-busy flag to the status read-out.
REQ-013 SHALL provide ports flag_A and flag_B, output, 1 each, latched timer flags.
REQ-014 SHALL provide port adpcm_flags, output, 3, latched ADPCM flags as {ZERO, BRDY, EOS}.
REQ-015 SHALL provide port irq_n, output, 1, active-low interrupt request.

Function
REQ-016 SHALL hold a 5-bit mask register, bit order {ZERO, BRDY, EOS, B, A}, loaded from din[4:0] on flagctl_we; mask bit 1 = flag disabled.
REQ-017 SHALL clear all five flags on flagctl_we with din[7]=1; in that case the mask SHALL NOT be updated.
REQ-018 SHALL set a flag on the rising clock edge after its event pulse when the flag's mask bit is 0; for ZERO, the event is a zero_lvl rising edge detected with a registered previous value.
REQ-019 SHALL force a flag to 0 while its mask bit is 1, including a flag already set when the mask is written.
REQ-020 SHALL clear flag_A on clr_A and flag_B on clr_B.
REQ-021 When a set event and a clear (clr_x or din[7] reset) occur in the same cycle, the set SHALL win; mask forcing SHALL override both.
REQ-022 SHALL keep flags sticky; only the clear sources in REQ-017, REQ-019 and REQ-020 lower them.
REQ-023 SHALL drive irq_n as a registered NOR of the five flags, one cycle after flag change.
REQ-024 SHALL raise busy in the cycle after write with a0=1, independent of cen, and load the counter with BUSY_CYCLES.
REQ-025 SHALL decrement the counter only on cycles where cen=1 and the counter is nonzero; busy SHALL fall in the cycle after the counter reaches 0.
REQ-026 A data write while busy SHALL reload the counter with BUSY_CYCLES, without a glitch on busy.
REQ-027 Address writes (a0=0) SHALL NOT affect busy.
REQ-028 SHALL leave flag behaviour independent of cen.

Reset
REQ-029 On rst, SHALL set busy=0, counter=0, all flags=0, mask=5'b00000, previous zero_lvl=0 and irq_n=1, immediately and asynchronously.
REQ-030 After rst is released mid-countdown, SHALL keep busy low until the next data write.

Structure
REQ-031 SHALL place the flag bit-index constants (A=0, B=1, EOS=2, BRDY=3, ZERO=4) and the BUSY_CYCLES default in shared package jt12_pkg.
REQ-032 SHALL implement the busy counter as sub-module jt12_busy_cnt; flag logic stays in the top.

Verification
REQ-033 Bench SHALL cover: reset, then ovf_A pulse -> flag_A=1 next cycle, irq_n=0 one cycle later; clr_A -> flag_A=0, irq_n=1.
REQ-034 Bench SHALL cover: flagctl_we with din=8'h02, then ovf_B -> flag_B stays 0; irq_n stays 1.
REQ-035 Bench SHALL cover: eos_ev pulse in the same cycle as flagctl_we with din=8'h80 -> EOS flag=1 and other flags=0.
REQ-036 Bench SHALL cover: with BUSY_CYCLES=4 and cen every 2nd cycle, a data write -> busy high for exactly 8 to 9 clk cycles; a second write at cycle 3 extends busy by 4 cen cycles.
REQ-037 Bench SHALL cover: zero_lvl held high for 10 cycles -> a single ZERO set; after din[7] reset, ZERO stays 0 until the next rising edge.
REQ-038 Bench SHALL cover: rst asserted mid-countdown with flags set -> all outputs return to their reset values without waiting for a clock edge.
